// File: rtl/booth_mul4_seq.sv
// Sequential radix-2 Booth controller for 4x4 signed multiplication.
// Each CALC cycle runs one Booth step. The add/subtract itself is done by an external 4-bit stage.
module booth_mul4_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic [3:0] adder_x,
  output logic [3:0] adder_y,
  output logic       adder_sub,
  input  logic [3:0] adder_z,
  input  logic       adder_cout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] mq_q, mq_d;
  logic       qm1_q, qm1_d;
  logic [3:0] mcand_q, mcand_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;

  logic       step_op;
  logic [3:0] step_s;
  logic       step_e;

  // Adder operands come only from registers, so the path through the external stage cannot loop.
  assign adder_x   = acc_q;
  assign adder_y   = mcand_q;
  assign adder_sub = mq_q[0] & ~qm1_q;

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = product_q;

  // Pairs 01 and 10 use the stage result. The sign bit is rebuilt as bit 4 of the
  // sign-extended sum, which keeps M = -8 exact.
  assign step_op = mq_q[0] ^ qm1_q;
  assign step_s  = step_op ? adder_z : acc_q;
  assign step_e  = step_op ? (acc_q[3] ^ mcand_q[3] ^ adder_sub ^ adder_cout) : acc_q[3];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    qm1_d     = qm1_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = 4'd0;
          mq_d    = b;
          qm1_d   = 1'b0;
          mcand_d = a;
          cnt_d   = 2'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = {step_e, step_s[3:1]};
        mq_d  = {step_s[0], mq_q[3:1]};
        qm1_d = mq_q[0];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          product_d = {step_e, step_s[3:1], step_s[0], mq_q[3:1]};
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= 4'd0;
      mq_q      <= 4'd0;
      qm1_q     <= 1'b0;
      mcand_q   <= 4'd0;
      cnt_q     <= 2'd0;
      product_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      qm1_q     <= qm1_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_booth_mul4_seq.sv
// Bench for booth_mul4_seq: a behavioural add/sub stage, a table of known products, sequences for
// start-while-busy and mid-run reset, and exhaustive and random runs checked against signed arithmetic.
module tb_booth_mul4_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a, b;
  logic       busy, done;
  logic [7:0] product;
  logic [3:0] adder_x, adder_y, adder_z;
  logic       adder_sub, adder_cout;

  int n_chk = 0;
  int n_fail = 0;
  int starts = 0;
  int done_seen = 0;

  booth_mul4_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .adder_x(adder_x), .adder_y(adder_y), .adder_sub(adder_sub),
    .adder_z(adder_z), .adder_cout(adder_cout)
  );

  always #5 clk = ~clk;

  // The add/subtract stage: x + y, or x + ~y + 1 when subtracting.
  always_comb begin
    logic [4:0] sum;
    sum = {1'b0, adder_x} + {1'b0, (adder_sub ? ~adder_y : adder_y)} + {4'd0, adder_sub};
    adder_z    = sum[3:0];
    adder_cout = sum[4];
  end

  always @(negedge clk) if (done === 1'b1) done_seen++;

  typedef struct {
    logic [3:0] av;
    logic [3:0] bv;
    logic [7:0] exp;
  } vec_t;

  function automatic logic [7:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
    int xi, yi;
    xi = $signed(x);
    yi = $signed(y);
    return 8'(xi * yi);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One multiply: start at cycle 0, busy cycles 1-4, done at cycle 5. Operands are scrambled
  // after acceptance to show they are only needed in the start cycle.
  task automatic run_mul(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] exp);
    logic [7:0] prev;
    bit busy_ok, sub_ok, y_ok, hold_ok;
    logic cur_bit, prev_bit;
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    starts++;
    prev = product;
    busy_ok = 1; sub_ok = 1; y_ok = 1; hold_ok = 1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      a = 4'($urandom); b = 4'($urandom);
      if (k <= 4) begin
        cur_bit  = bv[k-1];
        prev_bit = (k == 1) ? 1'b0 : bv[k-2];
        if (busy !== 1'b1 || done !== 1'b0) busy_ok = 0;
        if (adder_sub !== (cur_bit & ~prev_bit)) sub_ok = 0;
        if (adder_y !== av) y_ok = 0;
        if (product !== prev) hold_ok = 0;
      end
    end
    chk("busy_window", busy_ok, 1);
    chk("adder_sub_seq", sub_ok, 1);
    chk("adder_y_const", y_ok, 1);
    chk("product_hold_during_calc", hold_ok, 1);
    chk("done_pulse", {busy, done}, 2'b01);
    chk("product", product, exp);
    $display("mul a=%0d b=%0d product=0x%02h expected=0x%02h",
             $signed(av), $signed(bv), product, exp);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{4'h3, 4'h5, 8'h0F};
    vecs[1] = '{4'h8, 4'h8, 8'h40};
    vecs[2] = '{4'h8, 4'h7, 8'hC8};
    vecs[3] = '{4'h7, 4'h8, 8'hC8};
    vecs[4] = '{4'hF, 4'hF, 8'h01};
    vecs[5] = '{4'h0, 4'hB, 8'h00};
    vecs[6] = '{4'h5, 4'hD, 8'hF1};

    rst_n = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, product, adder_x, adder_y, adder_sub}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_mul(vecs[i].av, vecs[i].bv, vecs[i].exp);
      if (i == 0) begin
        repeat (3) @(negedge clk);
        chk("product_hold_idle", product, 8'h0F);
      end
    end

    // start held high throughout: second run must use the operands present at cycle 6
    @(negedge clk);
    start = 1'b1; a = 4'd3; b = 4'd5; starts += 2;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      a = 4'($urandom); b = 4'($urandom);
      if (k == 5) begin
        chk("busy_start_first_done", {busy, done}, 2'b01);
        chk("busy_start_first_product", product, 8'h0F);
      end
      if (k == 6) begin
        chk("busy_start_idle_gap", {busy, done}, 2'b00);
        a = 4'd2; b = 4'd6;
      end
      if (k == 7) chk("busy_start_second_busy", busy, 1'b1);
      if (k == 11) begin
        chk("busy_start_second_done", done, 1'b1);
        chk("busy_start_second_product", product, 8'h0C);
        start = 1'b0;
      end
    end
    $display("start-held sequence product=0x%02h", product);

    // reset in the middle of 3x5
    @(negedge clk);
    start = 1'b1; a = 4'd3; b = 4'd5;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", {busy, done, product, adder_sub, adder_x, adder_y}, 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midreset_no_done", done_seen, starts);
    chk("midreset_product_zero", product, 8'h00);
    $display("mid-run reset product=0x%02h done_count=%0d", product, done_seen);

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        run_mul(4'(ai), 4'(bi), ref_mul(4'(ai), 4'(bi)));

    for (int r = 0; r < 20; r++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom); rb = 4'($urandom);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_mul(ra, rb, ref_mul(ra, rb));
    end

    repeat (3) @(negedge clk);
    chk("done_count", done_seen, starts);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
